// File: rtl/matrix_vec_pkg.sv
// Shared state encoding and width/limit helpers for the sequential matrix-vector MAC.
package matrix_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned LIM_W = 128;

    function automatic int unsigned prod_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned dim);
        return (dim < 2) ? 1 : $clog2(dim);
    endfunction

    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned dim);
        return prod_w(data_w) + cnt_w(dim);
    endfunction

    // Clamp limits, valid in the low out_w bits of the returned vector.
    function automatic logic [LIM_W-1:0] sat_max(input int unsigned out_w);
        return (LIM_W'(1) << (out_w - 1)) - LIM_W'(1);
    endfunction

    function automatic logic [LIM_W-1:0] sat_min(input int unsigned out_w);
        return ~sat_max(out_w);
    endfunction

    localparam int unsigned PROD_W = prod_w(16);
    localparam int unsigned SUM_W  = sum_w(16, 4);
    localparam int unsigned CNT_W  = cnt_w(4);

endpackage

// File: rtl/matrix_vec_mac_seq_vec_dot_sat.sv
// Combinational signed dot product of one matrix row with X, rescaled and narrowed to OUT_W.
module vec_dot_sat
    import matrix_vec_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DIM       = 4,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned SAT       = 0
) (
    input  logic [DIM*DATA_W-1:0] row,
    input  logic [DIM*DATA_W-1:0] x,
    output logic [OUT_W-1:0]      y,
    output logic                  ovf
);

    localparam int unsigned PROD_BITS = prod_w(DATA_W);
    localparam int unsigned SUM_BITS  = sum_w(DATA_W, DIM);
    localparam logic [OUT_W-1:0] MAX_POS = OUT_W'(sat_max(OUT_W));
    localparam logic [OUT_W-1:0] MIN_NEG = OUT_W'(sat_min(OUT_W));

    logic signed [DATA_W-1:0]    a_e [DIM];
    logic signed [DATA_W-1:0]    x_e [DIM];
    logic signed [PROD_BITS-1:0] prod;
    logic signed [SUM_BITS-1:0]  acc;
    logic signed [SUM_BITS-1:0]  sh;

    for (genvar c = 0; c < DIM; c++) begin : g_unpack
        assign a_e[c] = row[(DIM-c)*DATA_W-1 -: DATA_W];
        assign x_e[c] = x[(DIM-c)*DATA_W-1 -: DATA_W];
    end

    // Guard bits in SUM_BITS make the accumulation exact for any operands.
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int unsigned c = 0; c < DIM; c++) begin
            prod = PROD_BITS'(a_e[c]) * PROD_BITS'(x_e[c]);
            acc  = acc + {{(SUM_BITS-PROD_BITS){prod[PROD_BITS-1]}}, prod};
        end
        sh = acc >>> FRAC_BITS;
    end

    if (OUT_W > SUM_BITS) begin : g_wide
        assign y   = {{(OUT_W-SUM_BITS){sh[SUM_BITS-1]}}, sh};
        assign ovf = 1'b0;
    end else if (OUT_W == SUM_BITS) begin : g_same
        assign y   = sh;
        assign ovf = 1'b0;
    end else begin : g_narrow
        logic [SUM_BITS-OUT_W:0] hi_bits;
        logic                    fits;

        // Fits iff every bit from the OUT_W sign position upward agrees.
        assign hi_bits = sh[SUM_BITS-1:OUT_W-1];
        assign fits    = (&hi_bits) | ~(|hi_bits);
        assign ovf     = ~fits;

        if (SAT != 0) begin : g_sat
            assign y = fits ? sh[OUT_W-1:0] : (sh[SUM_BITS-1] ? MIN_NEG : MAX_POS);
        end else begin : g_wrap
            assign y = sh[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/matrix_vec_mac_seq.sv
// Sequential Y = A*X: captures A/X, computes one row per cycle, holds Y until consumed.
module matrix_vec_mac_seq
    import matrix_vec_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DIM       = 4,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned FRAC_BITS = 0,
    parameter int unsigned SAT       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIM*DIM*DATA_W-1:0] a_flat,
    input  logic [DIM*DATA_W-1:0]     x_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIM*OUT_W-1:0]      y_flat,
    output logic                      ovf
);

    localparam int unsigned CNT_BITS = cnt_w(DIM);
    localparam logic [CNT_BITS-1:0] LAST_ROW = CNT_BITS'(DIM - 1);

    state_t                    state, state_nxt;
    logic [DIM*DIM*DATA_W-1:0] a_q;
    logic [DIM*DATA_W-1:0]     x_q;
    logic [CNT_BITS-1:0]       row_q;
    logic [OUT_W-1:0]          y_q [DIM];
    logic                      ovf_q;
    logic [DIM*DATA_W-1:0]     a_rows [DIM];
    logic [DIM*DATA_W-1:0]     a_row;
    logic [OUT_W-1:0]          row_y;
    logic                      row_ovf;

    for (genvar r = 0; r < DIM; r++) begin : g_rows
        assign a_rows[r] = a_q[(DIM*DIM-r*DIM)*DATA_W-1 -: DIM*DATA_W];
        assign y_flat[(DIM-r)*OUT_W-1 -: OUT_W] = y_q[r];
    end

    assign a_row = a_rows[row_q];

    vec_dot_sat #(
        .DATA_W   (DATA_W),
        .DIM      (DIM),
        .OUT_W    (OUT_W),
        .FRAC_BITS(FRAC_BITS),
        .SAT      (SAT)
    ) u_dot (
        .row(a_row),
        .x  (x_q),
        .y  (row_y),
        .ovf(row_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (row_q == LAST_ROW) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        ovf       = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            x_q   <= '0;
            row_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned r = 0; r < DIM; r++) y_q[r] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_flat;
                        x_q   <= x_flat;
                        row_q <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                CALC: begin
                    y_q[row_q] <= row_y;
                    ovf_q      <= ovf_q | row_ovf;
                    row_q      <= row_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_vec_mac_seq.sv
// Scoreboard bench: four configurations run the same jobs in lockstep against a longint reference model.
module tb_matrix_vec_mac_seq;

    typedef logic [3:0][128:0] exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [255:0] a_flat = '0;
    logic [63:0]  x_flat = '0;
    logic [3:0]   rdy, vld, ovobs;
    logic [127:0] y0, y3;
    logic [63:0]  y1, y2;
    logic [127:0] yobs [4];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb [$];

    int ow [4] = '{32, 16, 16, 32};
    int fb [4] = '{0, 0, 0, 8};
    int st [4] = '{0, 1, 0, 0};

    always #5 clk = ~clk;

    matrix_vec_mac_seq u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .a_flat(a_flat), .x_flat(x_flat), .out_valid(vld[0]), .out_ready(out_ready),
        .y_flat(y0), .ovf(ovobs[0])
    );
    matrix_vec_mac_seq #(.OUT_W(16), .SAT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .a_flat(a_flat), .x_flat(x_flat), .out_valid(vld[1]), .out_ready(out_ready),
        .y_flat(y1), .ovf(ovobs[1])
    );
    matrix_vec_mac_seq #(.OUT_W(16), .SAT(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .a_flat(a_flat), .x_flat(x_flat), .out_valid(vld[2]), .out_ready(out_ready),
        .y_flat(y2), .ovf(ovobs[2])
    );
    matrix_vec_mac_seq #(.FRAC_BITS(8)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .a_flat(a_flat), .x_flat(x_flat), .out_valid(vld[3]), .out_ready(out_ready),
        .y_flat(y3), .ovf(ovobs[3])
    );

    assign yobs[0] = y0;
    assign yobs[1] = {64'd0, y1};
    assign yobs[2] = {64'd0, y2};
    assign yobs[3] = y3;

    // Reference: exact longint dot products, floor shift, then clamp or wrap.
    function automatic logic [128:0] model(input logic [255:0] a, input logic [63:0] x,
                                           input int w, input int frac, input int sat);
        logic [127:0]       y;
        logic               of;
        logic signed [15:0] ae, xe;
        longint             s, sh, hi, lo;
        y  = '0;
        of = 1'b0;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        for (int r = 0; r < 4; r++) begin
            s = 0;
            for (int c = 0; c < 4; c++) begin
                ae = 16'(a >> ((15 - (r * 4 + c)) * 16));
                xe = 16'(x >> ((3 - c) * 16));
                s  = s + longint'(ae) * longint'(xe);
            end
            sh = s >>> frac;
            if (sh > hi) begin
                of = 1'b1;
                if (sat != 0) sh = hi;
            end else if (sh < lo) begin
                of = 1'b1;
                if (sat != 0) sh = lo;
            end
            y = (y << w) | {64'd0, 64'(sh) & ((64'd1 << w) - 64'd1)};
        end
        return {of, y};
    endfunction

    task automatic start_job(input logic [255:0] a, input logic [63:0] x, output bit timeout);
        exp_t e;
        int   n;
        for (int k = 0; k < 4; k++) e[k] = model(a, x, ow[k], fb[k], st[k]);
        sb.push_back(e);
        a_flat   = a;
        x_flat   = x;
        in_valid = 1'b1;
        n        = 0;
        while (!rdy[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        timeout = !rdy[0];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc, output bit timeout);
        cyc = 0;
        while (!vld[0] && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        timeout = !vld[0];
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rdy[k] !== 1'b1 || vld[k] !== 1'b0 || yobs[k] !== '0 || ovobs[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b y=%h ovf=%b, want rdy=1 vld=0 y=0 ovf=0",
                         k, rdy[k], vld[k], yobs[k], ovobs[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        bit   to1, to2;
        int   cyc;
        exp_t e;
        start_job({16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0,
                   16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1},
                  {16'd1, 16'd2, 16'd3, 16'd4}, to1);
        wait_out(cyc, to2);
        n_tests++;
        if (to1 || to2 || cyc != 4) begin
            n_fail++;
            $display("FAIL identity_latency: got %0d edges (timeout=%b), want 4", cyc, to1 | to2);
        end
        n_tests++;
        if (y0 !== {32'd1, 32'd2, 32'd3, 32'd4} || ovobs[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL identity_const: y=%h ovf=%b, want 00000001000000020000000300000004 ovf=0", y0, ovobs[0]);
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (vld[k] !== 1'b1 || yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL identity dut%0d: vld=%b y=%h ovf=%b, want vld=1 y=%h ovf=%b",
                         k, vld[k], yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
        end
        release_out();
    endtask

    task automatic test_neg_row();
        bit   to1, to2;
        int   cyc;
        exp_t e;
        start_job({{4{16'hFFFF}}, 192'd0}, {16'd1, 16'd2, 16'd3, 16'd4}, to1);
        wait_out(cyc, to2);
        n_tests++;
        if (to1 || to2 || y0 !== {32'hFFFFFFF6, 96'd0} || ovobs[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL neg_row_const: y=%h ovf=%b, want fffffff6 followed by zeros, ovf=0", y0, ovobs[0]);
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL neg_row dut%0d: y=%h ovf=%b, want y=%h ovf=%b",
                         k, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
        end
        release_out();
    endtask

    task automatic test_sat();
        bit   to1, to2;
        int   cyc;
        exp_t e;
        start_job({{4{16'h7FFF}}, 192'd0}, {4{16'h7FFF}}, to1);
        wait_out(cyc, to2);
        n_tests++;
        if (to1 || to2 || y1[63:48] !== 16'h7FFF || ovobs[1] !== 1'b1
            || y2[63:48] !== 16'h0004 || ovobs[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_const: sat y0=%h ovf=%b wrap y0=%h ovf=%b, want 7fff/1 and 0004/1",
                     y1[63:48], ovobs[1], y2[63:48], ovobs[2]);
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL sat dut%0d: y=%h ovf=%b, want y=%h ovf=%b",
                         k, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
        end
        release_out();
    endtask

    task automatic test_frac();
        logic [255:0] a [2];
        logic [63:0]  x [2];
        logic [127:0] want3 [2];
        bit           to1, to2;
        int           cyc;
        exp_t         e;
        a[0] = {16'h0100, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0100, 16'd0, 16'd0,
                16'd0, 16'd0, 16'h0100, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0100};
        x[0] = {16'h0180, 16'hFF80, 16'h0000, 16'h0001};
        want3[0] = {32'h00000180, 32'hFFFFFF80, 32'h00000000, 32'h00000001};
        a[1] = {16'hFFFF, 240'd0};
        x[1] = {16'h0001, 48'd0};
        want3[1] = {32'hFFFFFFFF, 96'd0};
        for (int j = 0; j < 2; j++) begin
            start_job(a[j], x[j], to1);
            wait_out(cyc, to2);
            n_tests++;
            if (to1 || to2 || y3 !== want3[j]) begin
                n_fail++;
                $display("FAIL frac_const job%0d: y=%h, want %h", j, y3, want3[j]);
            end
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                    n_fail++;
                    $display("FAIL frac job%0d dut%0d: y=%h ovf=%b, want y=%h ovf=%b",
                             j, k, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
                end
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] ys [4];
        logic [3:0]   ovs;
        bit           to1, to2;
        int           cyc;
        exp_t         e, e2;
        start_job({16{16'h0123}}, {16'h0002, 16'hFFFD, 16'h0004, 16'h0005}, to1);
        wait_out(cyc, to2);
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (to1 || to2 || yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL bp_first dut%0d: y=%h ovf=%b, want y=%h ovf=%b",
                         k, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
            ys[k] = yobs[k];
        end
        ovs = ovobs;
        // Second job offered while the first result is stalled.
        for (int k = 0; k < 4; k++) e2[k] = model({16{16'h8001}}, {4{16'h7FF0}}, ow[k], fb[k], st[k]);
        sb.push_back(e2);
        a_flat   = {16{16'h8001}};
        x_flat   = {4{16'h7FF0}};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (rdy[k] !== 1'b0 || vld[k] !== 1'b1 || yobs[k] !== ys[k] || ovobs[k] !== ovs[k]) begin
                    n_fail++;
                    $display("FAIL bp_hold cyc%0d dut%0d: rdy=%b vld=%b y=%h ovf=%b, want rdy=0 vld=1 y=%h ovf=%b",
                             i, k, rdy[k], vld[k], yobs[k], ovobs[k], ys[k], ovs[k]);
                end
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            n_fail++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1111 0000", rdy, vld);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_tests++;
        if (rdy !== 4'h0) begin
            n_fail++;
            $display("FAIL bp_accept: rdy=%b, want 0000", rdy);
        end
        wait_out(cyc, to2);
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (to2 || cyc != 4 || yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL bp_second dut%0d: lat=%0d y=%h ovf=%b, want lat=4 y=%h ovf=%b",
                         k, cyc, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        bit   to1, to2;
        int   cyc;
        exp_t e;
        start_job({16{16'h4321}}, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, to1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        e = sb.pop_back();
        #1;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (to1 || vld[k] !== 1'b0 || yobs[k] !== '0 || ovobs[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset dut%0d: vld=%b y=%h ovf=%b, want 0 0 0", k, vld[k], yobs[k], ovobs[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (rdy !== 4'hF || vld !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset_idle: rdy=%b vld=%b, want 1111 0000", rdy, vld);
        end
        start_job({16{16'h0007}}, {16'h0001, 16'hFFFF, 16'h0002, 16'h7FFF}, to1);
        wait_out(cyc, to2);
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (to1 || to2 || cyc != 4 || yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                n_fail++;
                $display("FAIL mid_reset_fresh dut%0d: lat=%0d y=%h ovf=%b, want lat=4 y=%h ovf=%b",
                         k, cyc, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
            end
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [255:0] a;
        logic [63:0]  x;
        bit           to1, to2;
        int           cyc;
        exp_t         e;
        for (int j = 0; j < 6; j++) begin
            if (j == 0) begin
                a = {16{16'h8000}};
                x = {4{16'h8000}};
            end else begin
                for (int i = 0; i < 8; i++) a = {a[223:0], 32'($urandom())};
                x = {32'($urandom()), 32'($urandom())};
            end
            start_job(a, x, to1);
            wait_out(cyc, to2);
            e = sb.pop_front();
            for (int k = 0; k < 4; k++) begin
                n_tests++;
                if (to1 || to2 || cyc != 4 || yobs[k] !== e[k][127:0] || ovobs[k] !== e[k][128]) begin
                    n_fail++;
                    $display("FAIL b2b job%0d dut%0d: lat=%0d y=%h ovf=%b, want lat=4 y=%h ovf=%b",
                             j, k, cyc, yobs[k], ovobs[k], e[k][127:0], e[k][128]);
                end
            end
            release_out();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_row();
        test_sat();
        test_frac();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_vec_mac_seq.md
Name: matrix_vec_mac_seq

Overview:
- Parametrised, sequential signed matrix × vector unit for the vertex-shader datapath: Y = A·X for a DIM×DIM matrix and a DIM vector.
- Computes one row per clock using DIM shared multipliers.
- Adds fixed-point rescale, optional saturation, an overflow flag and valid/ready handshakes on input and output.
- Sits between the vertex fetch stage and the transform/perspective stage.

Parameters:
- DATA_W, 16, signed element width of A and X.
- DIM, 4, matrix/vector dimension (≥2).
- OUT_W, 32, signed width of each Y element.
- FRAC_BITS, 0, arithmetic right shift applied to each row sum (fixed-point rescale).
- SAT, 0, 1 = saturate to OUT_W; 0 = two's-complement wrap (truncate).

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, A/X present.
- in_ready, out, 1, unit can accept a job.
- a_flat, in, DIM*DIM*DATA_W, matrix row-major; element (r,c) at bits [(DIM*DIM-r*DIM-c)*DATA_W-1 -: DATA_W], so (0,0) sits at the MSBs.
- x_flat, in, DIM*DATA_W, vector; element c at bits [(DIM-c)*DATA_W-1 -: DATA_W].
- out_valid, out, 1, Y valid.
- out_ready, in, 1, consumer accepts Y.
- y_flat, out, DIM*OUT_W, result; row r at bits [(DIM-r)*OUT_W-1 -: OUT_W].
- ovf, out, 1, at least one row saturated (SAT=1) or wrapped (SAT=0) in the current result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, row counter=0, out_valid=0, y_flat=0, ovf=0, captured A/X=0.
- in_ready = (state==IDLE), combinational. A transfer is any edge with in_valid && in_ready && rst_n high.

- IDLE:
  - On a transfer, register a_flat and x_flat, clear row counter and ovf, go to CALC.
  - Input buses are not sampled after this edge.
- CALC:
  - Each cycle, compute the sum over c of A[row][c]*X[c] for the current row and write it to y row slot `row`; OR any overflow into ovf.
  - Increment row. After the edge that writes row DIM-1, go to DONE.
- DONE:
  - out_valid=1; y_flat and ovf held stable.
  - On out_ready=1 at an edge, out_valid falls and the state returns to IDLE.
  - out_valid never drops without out_ready.
- Latency: out_valid is high DIM edges after the accept edge (4 cycles by default).
- Throughput: max one job per DIM+2 cycles. in_ready is low in CALC and DONE; in_valid there is ignored.
- y_flat is only written in CALC. Rows not yet written in CALC hold the previous job's values, and are undefined to consumers until out_valid.

Arithmetic per row:
- Product: DATA_W×DATA_W signed → 2*DATA_W.
- Sum: width SUM_W = 2*DATA_W + clog2(DIM); exact, with no internal overflow.
- Shift: arithmetic right shift by FRAC_BITS (floor toward −inf, no rounding).
- Narrow to OUT_W:
  - If the shifted sum fits in OUT_W, it is passed through (sign-extended if OUT_W is larger); ovf contribution is 0.
  - If it does not fit and SAT=1: clamp to +2^(OUT_W-1)-1 or −2^(OUT_W-1), ovf contribution is 1.
  - If it does not fit and SAT=0: keep the low OUT_W bits, ovf contribution is 1.
- Defaults reproduce plain 16×16 dot products into 32-bit lanes.
- Reset mid-CALC or mid-DONE aborts the job immediately and restores the reset values; no partial result is ever presented.

Decomposition:
- Package matrix_vec_pkg: state encoding (IDLE, CALC, DONE, 2-bit), localparams PROD_W, SUM_W, CNT_W = clog2(DIM), and saturation limit constants as functions of OUT_W.
- One combinational sub-module vec_dot_sat (params DATA_W, DIM, OUT_W, FRAC_BITS, SAT):
  - inputs: one row and X, flattened;
  - outputs: OUT_W result plus an overflow bit.
- Top module holds the FSM, the captured-operand registers, the row counter and the Y register.

Test Plan:
- Defaults; A=identity (0x0001 on the diagonal), X=(1,2,3,4); accept at edge T → out_valid at T+4, y=(1,2,3,4), ovf=0.
- Defaults; row0 all 0xFFFF, rows1-3 zero, X=(1,2,3,4) → Y0=0xFFFFFFF6 (−10), Y1..3=0, ovf=0.
- OUT_W=16, SAT=1; row0 all 0x7FFF, X all 0x7FFF → Y0=0x7FFF, ovf=1. Same case with SAT=0 → Y0=0x0004 (low 16 bits of 0xFFFC0004), ovf=1.
- FRAC_BITS=8; A=0x0100·identity, X=(0x0180,0xFF80,0,0x0001) → Y=(0x0180,0xFFFFFF80,0,0x00000001). A(0,0)=0xFFFF, X0=1, others 0 → Y0=−1 (floor).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → y_flat/ovf constant, in_ready=0, a second in_valid is ignored. Raise out_ready → in_ready=1 next cycle, and the second job is accepted and correct.
- Assert rst_n low during CALC row 2 → out_valid=0, y_flat=0, ovf=0 immediately. After release, in_ready=1 and a fresh job completes with the correct result.
